uart_buffered: RTL and testbench
================================

# uart_buffered

Parametrised, buffered successor to the plain UART: one TX serialiser and one RX deserialiser, each behind a synchronous FIFO. Adds configurable baud divisor, optional parity, RX error reporting and FIFO-threshold RTR flow control. Sits between the board pins and the program-loader byte stream, with valid/ready on the fabric side.

## Interface
- CLKS_PER_BIT, 108: clock cycles per bit (12.5 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 16: entries per FIFO; power of two, ≥ 4.
- PARITY, PARITY_NONE: PARITY_NONE, PARITY_EVEN or PARITY_ODD (uart_pkg::parity_t).
- RTR_THRESHOLD, FIFO_DEPTH-2: RX fill level at or above which uart_rtr drops.

- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input, idle high.
- uart_tx  out  1  serial output, idle high.
- uart_cts  in  1  peer may receive (high = clear); asynchronous.
- uart_rtr  out  1  we may receive (high = ready).
- read_data  out  8  head of RX FIFO.
- read_valid  out  1  RX FIFO not empty.
- read_ready  in  1  pop RX FIFO when read_valid is high.
- write_data  in  8  byte to transmit.
- write_valid  in  1  push request.
- write_ready  out  1  TX FIFO not full.
- rx_frame_error  out  1  one-cycle pulse: stop bit sampled low.
- rx_parity_error  out  1  one-cycle pulse: parity mismatch.
- rx_overrun  out  1  one-cycle pulse: good byte dropped, RX FIFO full.

## Operation
- Frame: start(0), 8 data bits LSB first, parity bit if PARITY ≠ NONE, one stop(1).
- TX FSM: IDLE → START → DATA (8 bits) → PARITY (skipped if NONE) → STOP → IDLE. Each state holds uart_tx for exactly CLKS_PER_BIT cycles.
- TX leaves IDLE only when the TX FIFO is non-empty and the synchronised uart_cts is high. It pops the FIFO on that cycle.
- CTS is checked only at frame start. Dropping CTS mid-frame lets the current frame complete.
- RX: uart_rx and uart_cts each pass through a 2-flop synchroniser.
- RX FSM: IDLE → START → DATA → PARITY (skipped if NONE) → STOP → IDLE.
  - IDLE: a high→low transition on the synchronised line enters START.
  - START: the line is re-sampled after CLKS_PER_BIT/2 cycles. If it is high, this is a false start and the FSM returns to IDLE.
  - All later bits are sampled every CLKS_PER_BIT cycles, centred on each bit.
- At STOP sample, exactly one of the following applies (priority order):
  1. Stop bit low: rx_frame_error pulses; byte discarded.
  2. Parity mismatch: rx_parity_error pulses; byte discarded.
  3. RX FIFO full (and no pop this cycle): rx_overrun pulses; byte discarded.
  4. Otherwise the byte is pushed.
- RX returns to IDLE right after the stop sample, half a bit early, for resynchronisation.
- FIFOs:
  - A push and a pop in the same cycle both succeed when the FIFO is non-empty.
  - A push into a full FIFO succeeds only if a pop occurs in the same cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the remaining bits are equal.
- uart_rtr is registered: next value is (rx_count < RTR_THRESHOLD).

## Timing
- Reset values:
  - uart_tx = 1, uart_rtr = 0.
  - read_valid = 0, read_data = 0, write_ready = 0.
  - All error pulses = 0; both FSMs in IDLE; FIFOs empty.
- Asserting reset_n low mid-frame aborts immediately: uart_tx goes high asynchronously and FIFO contents are lost.
- Cycle 1 after reset release: uart_rtr = 1 and write_ready = 1.
- read_data and read_valid are registered FIFO outputs. A pushed byte is visible one cycle after the push. A pop updates read_data on the next cycle.
- TX latency, from write accept to the uart_tx falling edge with FIFO empty, TX idle and CTS stable high: 2 cycles (FIFO register, then FSM).
- CTS latency: 2 cycles of synchroniser before it can gate a start.
- RX push: occurs 1 cycle after the stop-bit sample cycle. Error pulses are asserted on that same cycle.
- Bit period is exact, with no cumulative drift: the counter reloads to CLKS_PER_BIT-1 on every bit boundary.

## Structure
- uart_pkg:
  - parity_t enum.
  - tx_state_t and rx_state_t enums.
  - Function computing the parity bit from 8 data bits and parity_t.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH; ports push, pop, full, empty, count, registered head). Instantiated once for TX and once for RX.
- TX and RX FSMs live in uart_buffered itself.

## Test plan
- CLKS_PER_BIT=4, PARITY_NONE, CTS high. Write 0xA5 → uart_tx low for cycles 2–5 after accept, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high.
- Push 0x3C and 0xC3 back-to-back with CTS low → no start bit. Raise CTS → two frames with no idle gap between stop and next start. Drop CTS during the first frame → first frame completes, second does not start.
- PARITY_EVEN, drive frame 0x07 with parity bit 1 → byte 0x07 is read. Same frame with parity bit 0 → rx_parity_error pulses once; read_valid stays 0.
- Drive a frame with the stop bit low → rx_frame_error pulses. Drive a 1-cycle low glitch on uart_rx → no start; FSM returns to IDLE.
- FIFO_DEPTH=4, read_ready=0, send 5 bytes:
  - uart_rtr falls after byte 2.
  - Byte 5 → rx_overrun pulses.
  - Reading then returns bytes 1–4 in order.
- Assert reset_n low mid-TX-frame → uart_tx = 1 within the same cycle. After release, uart_rtr = 1, write_ready = 1 and read_valid = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the buffered UART: parity mode, TX/RX FSM state encodings
// and the parity-bit helper used by both the serialiser and the deserialiser.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE,
        PARITY_EVEN,
        PARITY_ODD
    } parity_t;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_t;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop
    } rx_state_t;

    // Parity bit to transmit (or expect) for a data byte; 0 when parity is off.
    function automatic logic parity_bit(input logic [7:0] data, input parity_t mode);
        case (mode)
            PARITY_EVEN: return ^data;
            PARITY_ODD:  return ~^data;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
// Ports: push/push_data write an entry (accepted when not full, or when a pop
// happens in the same cycle); pop removes the head when not empty; head holds the
// current oldest entry one cycle after it becomes the head; full, empty and count
// (0..DEPTH) are derived from wrapping pointers one bit wider than the address.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      rd_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{AW{1'b0}}, do_push};
            rd_ptr <= rd_next;
            // The incoming word becomes the head when it lands at the new read slot;
            // otherwise a pop exposes the next stored word.
            if (do_push && (wr_ptr == rd_next)) begin
                head <= push_data;
            end else if (do_pop) begin
                head <= mem[rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_buffered.sv
// Buffered UART: TX serialiser and RX deserialiser, each behind a uart_sync_fifo.
// Ports: clock/reset_n; uart_rx/uart_tx serial pins (idle high); uart_cts (peer clear,
// async) gates frame starts; uart_rtr drops when the RX FIFO reaches RTR_THRESHOLD;
// read_* is the RX FIFO valid/ready head; write_* pushes into the TX FIFO;
// rx_frame_error / rx_parity_error / rx_overrun are one-cycle pulses on the cycle a
// received byte would be pushed.
module uart_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = 108,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter parity_t     PARITY        = PARITY_NONE,
    parameter int unsigned RTR_THRESHOLD = FIFO_DEPTH - 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic       uart_tx,
    input  logic       uart_cts,
    output logic       uart_rtr,
    output logic [7:0] read_data,
    output logic       read_valid,
    input  logic       read_ready,
    input  logic [7:0] write_data,
    input  logic       write_valid,
    output logic       write_ready,
    output logic       rx_frame_error,
    output logic       rx_parity_error,
    output logic       rx_overrun
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   RTR_LEVEL = (AW + 1)'(RTR_THRESHOLD);

    // Synchronisers, RX edge history and the out-of-reset flag.
    logic rx_meta, rx_sync, rx_prev, cts_meta, cts_sync, ready_q, rtr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            cts_meta <= 1'b0;
            cts_sync <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            cts_meta <= uart_cts;
            cts_sync <= cts_meta;
            ready_q  <= 1'b1;
        end
    end

    // ---------------- TX path ----------------
    logic [7:0]  tx_head;
    logic        tx_full, tx_empty, tx_pop, tx_frame_end;
    logic [AW:0] tx_count;
    logic        unused_tx_count;

    assign write_ready     = ready_q && !tx_full;
    assign unused_tx_count = ^tx_count;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (write_valid && write_ready),
        .push_data (write_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    tx_state_t   tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_par, tx_line;

    // A new frame may start from idle or straight out of the last stop cycle.
    assign tx_frame_end = (tx_state == TxStop) && (tx_cnt == '0);
    assign tx_pop       = ((tx_state == TxIdle) || tx_frame_end) && !tx_empty && cts_sync;
    assign uart_tx      = tx_line;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TxIdle;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
        end else if (tx_pop) begin
            tx_state <= TxStart;
            tx_cnt   <= BIT_LAST;
            tx_shift <= tx_head;
            tx_par   <= parity_bit(tx_head, PARITY);
            tx_line  <= 1'b0;
        end else if (tx_state != TxIdle && tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
        end else begin
            tx_cnt <= BIT_LAST;
            unique case (tx_state)
                TxIdle: tx_cnt <= '0;
                TxStart: begin
                    tx_state <= TxData;
                    tx_bit   <= '0;
                    tx_line  <= tx_shift[0];
                end
                TxData: begin
                    tx_shift <= tx_shift >> 1;
                    if (tx_bit == 3'd7) begin
                        tx_state <= (PARITY != PARITY_NONE) ? TxParity : TxStop;
                        tx_line  <= (PARITY != PARITY_NONE) ? tx_par : 1'b1;
                    end else begin
                        tx_bit  <= tx_bit + 3'd1;
                        tx_line <= tx_shift[1];
                    end
                end
                TxParity: begin
                    tx_state <= TxStop;
                    tx_line  <= 1'b1;
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    // ---------------- RX path ----------------
    rx_state_t   rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift, rx_byte_q;
    logic        rx_par, rx_good_q, rx_frame_q, rx_parity_q;
    logic        rx_full, rx_empty, rx_pop;
    logic [AW:0] rx_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state    <= RxIdle;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shift    <= '0;
            rx_par      <= 1'b0;
            rx_byte_q   <= '0;
            rx_good_q   <= 1'b0;
            rx_frame_q  <= 1'b0;
            rx_parity_q <= 1'b0;
        end else begin
            rx_good_q   <= 1'b0;
            rx_frame_q  <= 1'b0;
            rx_parity_q <= 1'b0;
            if (rx_state == RxIdle) begin
                if (rx_prev && !rx_sync) begin
                    rx_state <= RxStart;
                    rx_cnt   <= HALF_LAST;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= BIT_LAST;
                unique case (rx_state)
                    RxStart: begin
                        rx_state <= rx_sync ? RxIdle : RxData;
                        rx_bit   <= '0;
                    end
                    RxData: begin
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= (PARITY != PARITY_NONE) ? RxParity : RxStop;
                        end
                    end
                    RxParity: begin
                        rx_par   <= rx_sync;
                        rx_state <= RxStop;
                    end
                    RxStop: begin
                        // Leave half a bit early so the next start edge is caught cleanly.
                        rx_state  <= RxIdle;
                        rx_byte_q <= rx_shift;
                        if (!rx_sync) begin
                            rx_frame_q <= 1'b1;
                        end else if (PARITY != PARITY_NONE &&
                                     rx_par != parity_bit(rx_shift, PARITY)) begin
                            rx_parity_q <= 1'b1;
                        end else begin
                            rx_good_q <= 1'b1;
                        end
                    end
                    default: rx_state <= RxIdle;
                endcase
            end
        end
    end

    assign rx_pop     = read_ready && read_valid;
    assign read_valid = !rx_empty;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rx_good_q),
        .push_data (rx_byte_q),
        .pop       (read_ready),
        .head      (read_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // Overrun depends on a same-cycle pop, so it is decided on the push cycle itself.
    assign rx_frame_error  = rx_frame_q;
    assign rx_parity_error = rx_parity_q;
    assign rx_overrun      = rx_good_q && rx_full && !rx_pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rtr_q <= 1'b0;
        end else begin
            rtr_q <= (rx_count < RTR_LEVEL);
        end
    end

    assign uart_rtr = rtr_q;

endmodule

// File: tb/tb_uart_buffered.sv
module tb_uart_buffered;
    import uart_pkg::*;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       uart_rx, uart_tx, uart_cts, uart_rtr;
    logic [7:0] read_data, write_data;
    logic       read_valid, read_ready, write_valid, write_ready;
    logic       rx_frame_error, rx_parity_error, rx_overrun;

    always #5 clock = ~clock;

    uart_buffered #(
        .CLKS_PER_BIT  (4),
        .FIFO_DEPTH    (4),
        .PARITY        (PARITY_EVEN),
        .RTR_THRESHOLD (2)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .uart_rx         (uart_rx),
        .uart_tx         (uart_tx),
        .uart_cts        (uart_cts),
        .uart_rtr        (uart_rtr),
        .read_data       (read_data),
        .read_valid      (read_valid),
        .read_ready      (read_ready),
        .write_data      (write_data),
        .write_valid     (write_valid),
        .write_ready     (write_ready),
        .rx_frame_error  (rx_frame_error),
        .rx_parity_error (rx_parity_error),
        .rx_overrun      (rx_overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    int frame_cnt = 0, parity_cnt = 0, overrun_cnt = 0;

    always @(negedge clock) begin
        if (rx_frame_error)  frame_cnt++;
        if (rx_parity_error) parity_cnt++;
        if (rx_overrun)      overrun_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        int n = 0;
        while (!write_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!write_ready) check("wr_ready_timeout", 0, 1);
        write_data  = b;
        write_valid = 1'b1;
        txq.push_back(b);
        @(negedge clock);
        write_valid = 1'b0;
    endtask

    // Cycle-exact check; entered on cycle 1 after the accept.
    task automatic tx_wave_check();
        logic [7:0] exp;
        logic       bit_exp;
        if (txq.size() == 0) begin
            check("tx_wave_noexp", 0, 1);
            return;
        end
        exp = txq.pop_front();
        check("tx_wave_c1", uart_tx, 1);
        for (int c = 2; c <= 45; c++) begin
            @(negedge clock);
            if (c <= 5)       bit_exp = 1'b0;
            else if (c <= 37) bit_exp = exp[(c - 6) / 4];
            else if (c <= 41) bit_exp = ^exp;
            else              bit_exp = 1'b1;
            check($sformatf("tx_wave_c%0d", c), uart_tx, bit_exp);
        end
    endtask

    // Decode one TX frame, sampling mid-bit; optionally drop CTS at a given offset.
    task automatic tx_frame(input int cts_drop_off, output int waited);
        logic [7:0] d, exp;
        logic       st, par, stp;
        waited = 0;
        d = '0; st = 1'b1; par = 1'b0; stp = 1'b0;
        while (uart_tx !== 1'b0 && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        if (uart_tx !== 1'b0) begin
            check("tx_start_timeout", 0, 1);
            return;
        end
        for (int off = 1; off <= 42; off++) begin
            @(negedge clock);
            if (off == cts_drop_off) uart_cts = 1'b0;
            if (off == 2) st = uart_tx;
            else if (off >= 6 && off <= 34 && (off - 6) % 4 == 0) d[(off - 6) / 4] = uart_tx;
            else if (off == 38) par = uart_tx;
            else if (off == 42) stp = uart_tx;
        end
        if (txq.size() == 0) begin
            check("tx_unexpected_frame", 1, 0);
            return;
        end
        exp = txq.pop_front();
        check("tx_start_bit", st, 0);
        check("tx_data", d, exp);
        check("tx_parity", par, ^exp);
        check("tx_stop_bit", stp, 1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            uart_rx = bits[i];
            repeat (4) @(negedge clock);
        end
        uart_rx = 1'b1;
    endtask

    task automatic rx_read();
        int n = 0;
        logic [7:0] exp;
        while (!read_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!read_valid) begin
            check("rx_valid_timeout", 0, 1);
            return;
        end
        if (rxq.size() == 0) begin
            check("rx_unexpected_byte", 1, 0);
            return;
        end
        exp = rxq.pop_front();
        check("rx_data", read_data, exp);
        read_ready = 1'b1;
        @(negedge clock);
        read_ready = 1'b0;
    endtask

    initial begin
        int w, lows, fc, pc, oc;
        logic [7:0] ob [5];
        ob[0] = 8'h01; ob[1] = 8'h80; ob[2] = 8'hFF; ob[3] = 8'h3C; ob[4] = 8'h99;

        reset_n = 1'b0; uart_rx = 1'b1; uart_cts = 1'b1;
        write_valid = 1'b0; write_data = '0; read_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tx", uart_tx, 1);
        check("rst_rtr", uart_rtr, 0);
        check("rst_read_valid", read_valid, 0);
        check("rst_read_data", read_data, 0);
        check("rst_write_ready", write_ready, 0);
        check("rst_pulses", {rx_frame_error, rx_parity_error, rx_overrun}, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rel_rtr", uart_rtr, 1);
        check("rel_write_ready", write_ready, 1);
        repeat (4) @(negedge clock);

        // Exact TX waveform
        write_byte(8'hA5);
        tx_wave_check();
        repeat (4) @(negedge clock);

        // CTS low holds both frames; release gives back-to-back frames
        uart_cts = 1'b0;
        repeat (4) @(negedge clock);
        write_byte(8'h3C);
        write_byte(8'hC3);
        lows = 0;
        repeat (30) begin
            @(negedge clock);
            if (!uart_tx) lows++;
        end
        check("cts_low_no_start", lows, 0);
        uart_cts = 1'b1;
        tx_frame(-1, w);
        tx_frame(-1, w);
        check("tx_no_gap", w, 2);
        repeat (4) @(negedge clock);

        // CTS dropped mid-frame: frame completes, next is held
        write_byte(8'h11);
        write_byte(8'h22);
        tx_frame(10, w);
        lows = 0;
        repeat (60) begin
            @(negedge clock);
            if (!uart_tx) lows++;
        end
        check("cts_drop_holds_next", lows, 0);
        uart_cts = 1'b1;
        tx_frame(-1, w);
        repeat (4) @(negedge clock);

        // RX good frame with even parity
        rxq.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clock);
        rx_read();
        check("rx_empty_after_read", read_valid, 0);

        // Parity error
        pc = parity_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (6) @(negedge clock);
        check("rx_parity_pulse", parity_cnt - pc, 1);
        check("rx_parity_no_push", read_valid, 0);

        // Frame error
        fc = frame_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (6) @(negedge clock);
        check("rx_frame_pulse", frame_cnt - fc, 1);
        check("rx_frame_no_push", read_valid, 0);

        // One-cycle glitch, then a good frame
        fc = frame_cnt; pc = parity_cnt; oc = overrun_cnt;
        uart_rx = 1'b0;
        @(negedge clock);
        uart_rx = 1'b1;
        repeat (20) @(negedge clock);
        check("glitch_no_event", (frame_cnt - fc) + (parity_cnt - pc) + (overrun_cnt - oc), 0);
        check("glitch_no_push", read_valid, 0);
        rxq.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1);
        repeat (4) @(negedge clock);
        rx_read();

        // Fill RX FIFO, RTR threshold, overrun, then drain in order
        oc = overrun_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rxq.push_back(ob[i]);
            send_frame(ob[i], ^ob[i], 1'b1);
            repeat (4) @(negedge clock);
            if (i == 0) check("rtr_after_byte1", uart_rtr, 1);
            if (i == 1) check("rtr_after_byte2", uart_rtr, 0);
        end
        check("rx_overrun_pulse", overrun_cnt - oc, 1);
        for (int i = 0; i < 4; i++) rx_read();
        check("rx_drained", read_valid, 0);
        repeat (2) @(negedge clock);
        check("rtr_after_drain", uart_rtr, 1);

        // Reset mid-frame
        write_byte(8'h77);
        @(negedge clock);
        check("tx_in_start_bit", uart_tx, 0);
        #3 reset_n = 1'b0;
        #1;
        check("rst_async_tx", uart_tx, 1);
        check("rst_async_write_ready", write_ready, 0);
        check("rst_async_rtr", uart_rtr, 0);
        txq.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rel2_rtr", uart_rtr, 1);
        check("rel2_write_ready", write_ready, 1);
        check("rel2_read_valid", read_valid, 0);
        lows = 0;
        repeat (50) begin
            @(negedge clock);
            if (!uart_tx) lows++;
        end
        check("rel2_tx_idle", lows, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
